// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction-memory
// address and presents one instruction per cycle to the control decoder.
module fetch_unit #(
   parameter int unsigned     PC_W      = 8,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [7:0]      NOP_INSTR = 8'b10111000,
   parameter int unsigned     CNT_W     = 16
) (
   input  logic             clock_i,
   input  logic             resetn_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branchf_i,
   input  logic             branchb_i,
   input  logic [7:0]       branch_offset_i,
   output logic [PC_W-1:0]  imem_addr_o,
   input  logic [7:0]       imem_rdata_i,
   output logic [7:0]       instruction_o,
   output logic [PC_W-1:0]  pc_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] retired_cnt_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  r_ctrl_pc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_halted;

   state_t           w_state_next;
   logic [PC_W-1:0]  w_pc_next;
   logic [PC_W-1:0]  w_offset;
   logic [7:0]       w_instr;
   logic             w_redirect;
   logic             w_fetch_ok;

   // Branch targets are relative to the instruction the decoder is resolving,
   // not to the one currently being fetched, hence r_ctrl_pc.
   always_comb begin
      w_offset     = PC_W'(branch_offset_i);
      w_redirect   = branchf_i | branchb_i;
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_instr      = NOP_INSTR;
      w_fetch_ok   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pc_next = RESET_PC;
            if (start_i) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_redirect) begin
               w_pc_next = branchf_i ? (r_ctrl_pc + w_offset) : (r_ctrl_pc - w_offset);
            end else if (!stall_i) begin
               w_instr    = imem_rdata_i;
               w_fetch_ok = 1'b1;
               if (imem_rdata_i[7:3] == 5'b10001) w_state_next = S_HALT;
               else                               w_pc_next    = r_pc + PC_ONE;
            end
         end
         S_HALT: begin
            w_pc_next = r_pc;
         end
         default: begin
            w_state_next = S_IDLE;
            w_pc_next    = RESET_PC;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_ctrl_pc <= '0;
         r_cnt     <= '0;
         r_halted  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_ctrl_pc <= r_pc;
         r_halted  <= (w_state_next == S_HALT);
         if (w_fetch_ok && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
      end
   end

   assign imem_addr_o   = w_pc_next;
   assign instruction_o = w_instr;
   assign pc_o          = r_pc;
   assign halted_o      = r_halted;
   assign retired_cnt_o = r_cnt;
   assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, halt, branches with wrap,
// stalls, squashed halt and reset during a redirect.
module tb_fetch_unit;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        stall;
   logic        branchf;
   logic        branchb;
   logic [7:0]  offset;
   logic [7:0]  imem_addr;
   logic [7:0]  rdata;
   logic [7:0]  instr;
   logic [7:0]  pc;
   logic        halted;
   logic [15:0] cnt;
   logic [1:0]  dbg_state;

   logic [7:0]  mem [256];
   logic [15:0] exp_cnt;
   int          checks;
   int          failures;

   localparam logic [7:0] NOP = 8'b10111000;

   fetch_unit dut (
      .clock_i         (clk),
      .resetn_i        (resetn),
      .start_i         (start),
      .stall_i         (stall),
      .branchf_i       (branchf),
      .branchb_i       (branchb),
      .branch_offset_i (offset),
      .imem_addr_o     (imem_addr),
      .imem_rdata_i    (rdata),
      .instruction_o   (instr),
      .pc_o            (pc),
      .halted_o        (halted),
      .retired_cnt_o   (cnt),
      .dbg_state_o     (dbg_state)
   );

   // clock / reset block and synchronous instruction memory
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rdata <= mem[imem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_pattern();
      logic [7:0] a;
      for (int i = 0; i < 256; i++) begin
         a = 8'(i);
         mem[i] = {2'b01, a[5:0]};
      end
   endtask

   task automatic step(input logic f, input logic b, input logic [7:0] off, input logic st);
      @(negedge clk);
      start   = 1'b0;
      branchf = f;
      branchb = b;
      offset  = off;
      stall   = st;
      #1;
   endtask

   task automatic normal(input logic [7:0] p);
      logic [7:0] nxt;
      step(1'b0, 1'b0, 8'h00, 1'b0);
      nxt = p + 8'd1;
      chk($sformatf("pc@%0h", p),     32'(pc),        32'(p));
      chk($sformatf("instr@%0h", p),  32'(instr),     32'(mem[p]));
      chk($sformatf("addr@%0h", p),   32'(imem_addr), 32'(nxt));
      chk($sformatf("cnt@%0h", p),    32'(cnt),       32'(exp_cnt));
      chk($sformatf("halted@%0h", p), 32'(halted),    32'(1'b0));
      exp_cnt++;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_cnt  = '0;
      resetn   = 1'b0;
      start    = 1'b0;
      stall    = 1'b0;
      branchf  = 1'b0;
      branchb  = 1'b0;
      offset   = 8'h00;
      load_pattern();
      mem[0] = 8'h41;
      mem[1] = 8'h0A;
      mem[2] = 8'h12;
      mem[3] = 8'h88;

      // run A: straight-line program ending in halt
      repeat (2) @(negedge clk);
      chk("rst_instr",  32'(instr),     32'(NOP));
      chk("rst_addr",   32'(imem_addr), 32'(8'h00));
      chk("rst_pc",     32'(pc),        32'(8'h00));
      chk("rst_halted", 32'(halted),    32'(1'b0));
      chk("rst_cnt",    32'(cnt),       32'(16'h0));
      chk("rst_state",  32'(dbg_state), 32'(2'd0));

      @(negedge clk);
      resetn = 1'b1;
      start  = 1'b1;
      #1;
      chk("idle_instr", 32'(instr),     32'(NOP));
      chk("idle_addr",  32'(imem_addr), 32'(8'h00));

      for (int k = 0; k < 3; k++) normal(8'(k));
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("halt_instr", 32'(instr),     32'(8'h88));
      chk("halt_pc",    32'(pc),        32'(8'h03));
      chk("halt_addr",  32'(imem_addr), 32'(8'h03));
      chk("halt_cnt",   32'(cnt),       32'(16'd3));

      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("hs_halted", 32'(halted),    32'(1'b1));
      chk("hs_instr",  32'(instr),     32'(NOP));
      chk("hs_pc",     32'(pc),        32'(8'h03));
      chk("hs_cnt",    32'(cnt),       32'(16'd4));
      chk("hs_state",  32'(dbg_state), 32'(2'd2));

      step(1'b1, 1'b0, 8'h05, 1'b1);
      chk("hs_ign_addr",  32'(imem_addr), 32'(8'h03));
      chk("hs_ign_instr", 32'(instr),     32'(NOP));
      step(1'b0, 1'b1, 8'h05, 1'b0);
      chk("hs_hold_pc",     32'(pc),     32'(8'h03));
      chk("hs_hold_halted", 32'(halted), 32'(1'b1));
      chk("hs_hold_cnt",    32'(cnt),    32'(16'd4));

      // run B: branches, stalls, wrap, squashed halt, reset mid-redirect
      @(negedge clk);
      resetn  = 1'b0;
      branchf = 1'b0;
      branchb = 1'b0;
      load_pattern();
      mem[8'h0F] = 8'h8A;
      exp_cnt    = '0;
      #1;
      chk("rstB_halted", 32'(halted), 32'(1'b0));
      chk("rstB_pc",     32'(pc),     32'(8'h00));
      @(negedge clk);
      resetn = 1'b1;
      start  = 1'b1;

      for (int k = 0; k < 6; k++) normal(8'(k));
      step(1'b1, 1'b0, 8'd3, 1'b0);
      chk("fwd_instr", 32'(instr),     32'(NOP));
      chk("fwd_addr",  32'(imem_addr), 32'(8'h08));
      chk("fwd_cnt",   32'(cnt),       32'(16'd6));
      normal(8'h08);

      step(1'b0, 1'b1, 8'd1, 1'b0);
      chk("bwd_addr",  32'(imem_addr), 32'(8'h07));
      chk("bwd_instr", 32'(instr),     32'(NOP));
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         chk("stall_instr", 32'(instr),     32'(NOP));
         chk("stall_pc",    32'(pc),        32'(8'h07));
         chk("stall_addr",  32'(imem_addr), 32'(8'h07));
         chk("stall_cnt",   32'(cnt),       32'(16'd7));
      end
      normal(8'h07);

      step(1'b0, 1'b1, 8'd5, 1'b0);
      chk("bwd2_addr", 32'(imem_addr), 32'(8'h02));
      normal(8'h02);
      step(1'b0, 1'b1, 8'd5, 1'b0);
      chk("wrap_bwd_addr", 32'(imem_addr), 32'(8'hFD));
      normal(8'hFD);
      normal(8'hFE);
      normal(8'hFF);
      normal(8'h00);

      step(1'b1, 1'b0, 8'd10, 1'b0);
      chk("fwd10_addr", 32'(imem_addr), 32'(8'h0A));
      normal(8'h0A);
      step(1'b1, 1'b1, 8'd4, 1'b0);
      chk("both_addr",  32'(imem_addr), 32'(8'h0E));
      chk("both_instr", 32'(instr),     32'(NOP));
      normal(8'h0E);

      step(1'b1, 1'b0, 8'h20, 1'b0);
      chk("sqh_instr", 32'(instr),     32'(NOP));
      chk("sqh_addr",  32'(imem_addr), 32'(8'h2E));
      normal(8'h2E);
      chk("sqh_state", 32'(dbg_state), 32'(2'd1));

      step(1'b0, 1'b1, 8'd1, 1'b0);
      chk("pre_rst_addr", 32'(imem_addr), 32'(8'h2D));
      resetn = 1'b0;
      #1;
      chk("mid_rst_pc",     32'(pc),        32'(8'h00));
      chk("mid_rst_instr",  32'(instr),     32'(NOP));
      chk("mid_rst_cnt",    32'(cnt),       32'(16'h0));
      chk("mid_rst_halted", 32'(halted),    32'(1'b0));
      chk("mid_rst_addr",   32'(imem_addr), 32'(8'h00));
      chk("mid_rst_state",  32'(dbg_state), 32'(2'd0));
      @(negedge clk);
      branchb = 1'b0;
      chk("rst_hold_pc",  32'(pc),  32'(8'h00));
      chk("rst_hold_cnt", 32'(cnt), 32'(16'h0));
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_state", 32'(dbg_state), 32'(2'd0));
      chk("post_rst_instr", 32'(instr),     32'(NOP));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control decoder.
- Owns the program counter and drives the synchronous instruction-memory read address.
- Presents one 8-bit instruction per cycle to the decoder.
- Applies taken-branch redirects (branchf/branchb from the decoder), freezes on the halt opcode, and inserts NOP bubbles when squashing or stalling.

Parameters:
PC_W, 8, program counter / instruction memory address width
RESET_PC, 0, PC value loaded at reset and held in IDLE
NOP_INSTR, 8'b10111000, bubble opcode (decodes to no register, memory, CB or branch writes)
CNT_W, 16, width of retired-instruction counter

Ports:
clock_i  in  1  system clock, all state on rising edge
resetn_i  in  1  asynchronous active-low reset
start_i  in  1  leave IDLE and begin fetching (level, sampled in IDLE only)
stall_i  in  1  hold PC and present NOP this cycle
branchf_i  in  1  taken forward branch (registered decoder output)
branchb_i  in  1  taken backward branch (registered decoder output)
branch_offset_i  in  8  unsigned branch distance (rs register value)
imem_addr_o  out  PC_W  read address; memory returns mem[addr] in the following cycle
imem_rdata_i  in  8  instruction data, equals mem[pc_q] during the current cycle
instruction_o  out  8  instruction to decoder (latched by decoder at next edge)
pc_o  out  PC_W  PC of the presented instruction (pc_q)
halted_o  out  1  high in HALT state
retired_cnt_o  out  CNT_W  count of non-squashed instructions presented in RUN

Behaviour:
- Reset (asynchronous, resetn_i low): state=IDLE, pc_q=RESET_PC, ctrl_pc_q=0, retired_cnt=0, halted_o=0. Outputs while reset is held or in IDLE: instruction_o=NOP_INSTR, imem_addr_o=RESET_PC. Reset mid-run discards everything, with no partial redirect.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN when start_i=1.
  - RUN -> HALT when the presented instruction is unsquashed halt (instruction_o[7:3]=5'b10001).
  - HALT exits only via reset.
- imem_addr_o = pc_next (combinational), so imem_rdata_i corresponds to pc_q with no extra bubble.
- ctrl_pc_q <= pc_q every edge, including NOP, stall and squash cycles. It holds the PC of the instruction the decoder is currently resolving.
- RUN, per cycle, priority high to low:
  1. redirect = branchf_i | branchb_i:
     - instruction_o=NOP_INSTR (squash the in-flight fetch).
     - pc_next = ctrl_pc_q + branch_offset_i if branchf_i, else ctrl_pc_q - branch_offset_i.
     - Arithmetic is modulo 2^PC_W: offset is zero-extended or truncated to PC_W, and wrap-around is silent.
     - branchf_i wins if both are high.
     - Exactly one bubble per taken branch.
  2. stall_i: pc_next=pc_q, instruction_o=NOP_INSTR.
  3. normal: instruction_o=imem_rdata_i, pc_next=pc_q+1 (wraps at 2^PC_W-1 -> 0).
- Halt in normal slot: instruction_o=halt opcode is presented for exactly one cycle and pc_next=pc_q. The next state is HALT.
- A halt opcode in a squashed or stalled cycle is ignored.
- HALT: pc_q frozen, instruction_o=NOP_INSTR, halted_o=1. branchf_i/branchb_i/stall_i are ignored.
- retired_cnt increments by 1 on each RUN cycle whose instruction_o comes from imem_rdata_i (the halt instruction included). It saturates at all-ones.
- branch_offset_i is sampled only when redirect=1.

Test Plan:
- Reset then start_i=1 with mem[0..3]=8'h41,8'h0A,8'h12,8'h88: instruction_o sequence 41,0A,12,88 on consecutive cycles; pc_o 0,1,2,3; HALT next cycle; halted_o=1; retired_cnt_o=4; PC held at 3.
- Forward branch: decoder asserts branchf_i while ctrl_pc_q=5, offset=3 -> instruction_o=NOP that cycle, next cycle pc_o=8 and instruction_o=mem[8].
- Backward branch with wrap: ctrl_pc_q=2, branchb_i=1, offset=5, PC_W=8 -> next pc_o=8'hFD. branchf_i and branchb_i both high, ctrl_pc_q=10, offset=4 -> next pc_o=14.
- stall_i high 3 cycles at pc_q=7 -> three NOPs presented, pc_o stays 7, retired_cnt unchanged; on release instruction_o=mem[7].
- Halt opcode squashed by a same-cycle redirect -> no HALT entry, fetch resumes at the target. PC at 8'hFF advances to 8'h00 normally.
- resetn_i pulsed low mid-RUN during a redirect cycle -> immediately IDLE, pc_o=RESET_PC, instruction_o=NOP_INSTR, retired_cnt_o=0, halted_o=0.
